// File: rtl/iec_talker.sv
// iec_talker: IEC serial-bus talker. Sends one byte per request, LSB first,
// optionally under ATN, with EOI signalling and listener handshakes.
module iec_talker #(
    parameter int CLK_DIV = 32,    // clk32 cycles per 1 us tick
    parameter int BIT_US  = 60,    // CLK-low and CLK-high phase length
    parameter int EOI_US  = 200,   // listener's EOI detection threshold
    parameter int TMO_US  = 1000   // listener response timeout
) (
    input  logic       clk32,
    input  logic       reset_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_atn,
    input  logic       tx_eoi,
    output logic       tx_ready,
    output logic       done,
    output logic       error,
    output logic       busy,
    input  logic       iec_clk_i,
    input  logic       iec_data_i,
    output logic       iec_clk_o,
    output logic       iec_data_o,
    output logic       iec_atn_o
);

    localparam int ATN_HOLD_US = 20;
    // The timer must reach the longest interval the bus can involve without
    // saturating; EOI_US is included so the EOI window always fits.
    localparam int T_MAX_A = (TMO_US > EOI_US) ? TMO_US : EOI_US;
    localparam int T_MAX_B = (BIT_US > ATN_HOLD_US) ? BIT_US : ATN_HOLD_US;
    localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int TW      = $clog2(T_MAX + 2);
    localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [TW-1:0] T_BIT      = TW'(BIT_US);
    localparam logic [TW-1:0] T_TMO      = TW'(TMO_US);
    localparam logic [TW-1:0] T_HOLD     = TW'(ATN_HOLD_US);
    localparam logic [TW-1:0] T_SAT      = {TW{1'b1}};

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ATN_START,
        ST_READY,
        ST_EOI_WAIT,
        ST_EOI_ACK,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_FRAME_ACK,
        ST_ATN_END
    } state_t;

    state_t          r_state, w_state_nxt;
    logic            r_clk_s1, r_clk_s2, r_data_s1, r_data_s2;
    logic [PW-1:0]   r_presc;
    logic [TW-1:0]   r_timer;
    logic [1:0]      r_settle;
    logic [2:0]      r_bit, w_bit_nxt, w_bit_inc;
    logic [7:0]      r_byte;
    logic            r_is_atn, r_eoi;
    logic            r_atn_exit, w_atn_exit_nxt;
    logic            r_clk_o, r_data_o, r_atn_o, r_done, r_err;
    logic            w_clk_nxt, w_data_nxt, w_atn_nxt, w_done_nxt, w_err_nxt;
    logic            w_tick, w_settled, w_state_chg, w_accept, w_atn_held, w_fail;
    logic            w_exp_bit, w_exp_tmo, w_exp_hold;

    // Bring the asynchronous bus levels into the clk32 domain.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would collapse the two stages into one.
    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_s1  <= 1'b0;
            r_clk_s2  <= 1'b0;
            r_data_s1 <= 1'b0;
            r_data_s2 <= 1'b0;
        end else begin
            r_clk_s1  <= iec_clk_i;
            r_clk_s2  <= r_clk_s1;
            r_data_s1 <= iec_data_i;
            r_data_s2 <= r_data_s1;
        end
    end

    // Free-running prescaler: one-cycle us tick every CLK_DIV cycles.
    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else if (r_presc == PRESC_LAST) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign w_tick = (r_presc == PRESC_LAST);

    // Per-state us timer and a short settle count, both restarted on every
    // state change. The settle count hides the synchronizer latency so our
    // own previous drive on DATA is never mistaken for a listener response.
    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            r_timer  <= '0;
            r_settle <= '0;
        end else if (w_state_chg) begin
            r_timer  <= '0;
            r_settle <= '0;
        end else begin
            if (w_tick && (r_timer != T_SAT)) r_timer <= r_timer + 1'b1;
            if (r_settle != 2'd2) r_settle <= r_settle + 1'b1;
        end
    end

    // Expiry on the (N+1)th tick after entry gives N..N+1 us regardless of
    // prescaler phase.
    assign w_exp_bit  = w_tick && (r_timer == T_BIT);
    assign w_exp_tmo  = w_tick && (r_timer == T_TMO);
    assign w_exp_hold = w_tick && (r_timer == T_HOLD);
    assign w_settled  = (r_settle == 2'd2);
    assign w_state_chg = (w_state_nxt != r_state);
    assign w_accept   = tx_valid && (r_state == ST_IDLE);
    // ATN is held exactly while we are pulling the ATN line.
    assign w_atn_held = ~r_atn_o;
    assign w_bit_inc  = r_bit + 3'd1;

    // Capture the request payload on acceptance.
    // NOTE: payload registers carry no reset; they are only read after being
    // loaded on an accepted request.
    always_ff @(posedge clk32) begin
        if (w_accept) begin
            r_byte   <= tx_data;
            r_is_atn <= tx_atn;
            r_eoi    <= tx_eoi;
        end
    end

    // FSM state and registered bus/strobe outputs.
    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_clk_o    <= 1'b1;
            r_data_o   <= 1'b1;
            r_atn_o    <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_bit      <= 3'd0;
            r_atn_exit <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_clk_o    <= w_clk_nxt;
            r_data_o   <= w_data_nxt;
            r_atn_o    <= w_atn_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_bit      <= w_bit_nxt;
            r_atn_exit <= w_atn_exit_nxt;
        end
    end

    // Next-state and next-output logic; outputs change on state entry.
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_clk_nxt      = r_clk_o;
        w_data_nxt     = r_data_o;
        w_atn_nxt      = r_atn_o;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_bit_nxt      = r_bit;
        w_atn_exit_nxt = r_atn_exit;
        w_fail         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (tx_valid) begin
                    if (tx_atn && !w_atn_held) begin
                        w_state_nxt = ST_ATN_START;
                        w_atn_nxt   = 1'b0;
                        w_clk_nxt   = 1'b0;
                        w_data_nxt  = 1'b1;
                    end else if (!tx_atn && w_atn_held) begin
                        // Leave ATN mode before the data byte, no done pulse.
                        w_state_nxt    = ST_ATN_END;
                        w_atn_nxt      = 1'b1;
                        w_atn_exit_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_READY;
                        w_clk_nxt   = 1'b1;
                        w_data_nxt  = 1'b1;
                    end
                end
            end
            ST_ATN_START: begin
                // Listener edge is checked first so it wins over expiry.
                if (w_settled && !r_data_s2) begin
                    w_state_nxt = ST_READY;
                    w_clk_nxt   = 1'b1;
                    w_data_nxt  = 1'b1;
                end else if (w_exp_tmo) begin
                    w_fail = 1'b1;
                end
            end
            ST_READY: begin
                // Also require CLK really released: another device may hold it.
                if (w_settled && r_data_s2 && r_clk_s2) begin
                    if (!r_is_atn && r_eoi) begin
                        w_state_nxt = ST_EOI_WAIT;
                    end else begin
                        w_state_nxt = ST_BIT_LOW;
                        w_clk_nxt   = 1'b0;
                        w_data_nxt  = r_byte[0];
                        w_bit_nxt   = 3'd0;
                    end
                end
            end
            ST_EOI_WAIT: begin
                if (w_settled && !r_data_s2) begin
                    w_state_nxt = ST_EOI_ACK;
                end else if (w_exp_tmo) begin
                    w_fail = 1'b1;
                end
            end
            ST_EOI_ACK: begin
                if (w_settled && r_data_s2) begin
                    w_state_nxt = ST_BIT_LOW;
                    w_clk_nxt   = 1'b0;
                    w_data_nxt  = r_byte[0];
                    w_bit_nxt   = 3'd0;
                end
            end
            ST_BIT_LOW: begin
                if (w_exp_bit) begin
                    w_state_nxt = ST_BIT_HIGH;
                    w_clk_nxt   = 1'b1;
                end
            end
            ST_BIT_HIGH: begin
                if (w_exp_bit) begin
                    w_clk_nxt = 1'b0;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = ST_FRAME_ACK;
                        w_data_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_BIT_LOW;
                        w_bit_nxt   = w_bit_inc;
                        w_data_nxt  = r_byte[w_bit_inc];
                    end
                end
            end
            ST_FRAME_ACK: begin
                if (w_settled && !r_data_s2) begin
                    if (r_is_atn && r_eoi) begin
                        w_state_nxt = ST_ATN_END;
                        w_atn_nxt   = 1'b1;
                    end else begin
                        // CLK stays pulled in IDLE to hold the bus.
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end else if (w_exp_tmo) begin
                    w_fail = 1'b1;
                end
            end
            ST_ATN_END: begin
                if (w_exp_hold) begin
                    w_clk_nxt = 1'b1;
                    if (r_atn_exit) begin
                        w_state_nxt    = ST_READY;
                        w_data_nxt     = 1'b1;
                        w_atn_exit_nxt = 1'b0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Any timeout: release every line, drop ATN mode, report once.
        if (w_fail) begin
            w_state_nxt    = ST_IDLE;
            w_clk_nxt      = 1'b1;
            w_data_nxt     = 1'b1;
            w_atn_nxt      = 1'b1;
            w_err_nxt      = 1'b1;
            w_done_nxt     = 1'b0;
            w_atn_exit_nxt = 1'b0;
        end
    end

    assign tx_ready   = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;
    assign error      = r_err;
    assign iec_clk_o  = r_clk_o;
    assign iec_data_o = r_data_o;
    assign iec_atn_o  = r_atn_o;

endmodule

// File: tb/tb_iec_talker.sv
// Directed bench for iec_talker with a scripted listener on the bus.
`timescale 1ns/1ps
module tb_iec_talker;

    localparam int DIV    = 4;      // shortened us tick to keep runs brief
    localparam int BIT    = 60;
    localparam int TMO    = 1000;
    localparam int BIT_LO = BIT * DIV;
    localparam int BIT_HI = (BIT + 1) * DIV + 2;
    localparam int TMO_BUDGET = (TMO + 2) * DIV + 50;

    localparam int S_CLK  = 0;
    localparam int S_DATA = 1;
    localparam int S_ATN  = 2;
    localparam int S_DONE = 3;
    localparam int S_ERR  = 4;

    logic       clk32 = 1'b0;
    logic       reset_n;
    logic       tx_valid, tx_atn, tx_eoi;
    logic [7:0] tx_data;
    logic       tx_ready, done, error, busy;
    logic       iec_clk_i, iec_data_i, iec_clk_o, iec_data_o, iec_atn_o;
    logic       lst_data;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_done   = 0;
    int n_err    = 0;
    int n_accept = 0;
    int n_both   = 0;

    // Wired-AND bus: the listener only ever touches DATA.
    assign iec_clk_i  = iec_clk_o;
    assign iec_data_i = iec_data_o & lst_data;

    iec_talker #(.CLK_DIV(DIV)) dut (
        .clk32      (clk32),
        .reset_n    (reset_n),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_atn     (tx_atn),
        .tx_eoi     (tx_eoi),
        .tx_ready   (tx_ready),
        .done       (done),
        .error      (error),
        .busy       (busy),
        .iec_clk_i  (iec_clk_i),
        .iec_data_i (iec_data_i),
        .iec_clk_o  (iec_clk_o),
        .iec_data_o (iec_data_o),
        .iec_atn_o  (iec_atn_o)
    );

    always #16 clk32 = ~clk32;

    // Event counters sampled on the active edge.
    always @(posedge clk32) begin
        cyc <= cyc + 1;
        if (done) n_done <= n_done + 1;
        if (error) n_err <= n_err + 1;
        if (done && error) n_both <= n_both + 1;
        if (reset_n && tx_valid && tx_ready) n_accept <= n_accept + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input int val, input int lo, input int hi);
        n_assert++;
        assert (val >= lo && val <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, val, lo, hi);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            S_CLK:   return iec_clk_o;
            S_DATA:  return iec_data_o;
            S_ATN:   return iec_atn_o;
            S_DONE:  return done;
            default: return error;
        endcase
    endfunction

    // Wait (at negedges) until a DUT output reaches val, bounded by budget.
    task automatic wait_sig(input int sel, input logic val, input int budget,
                            input string tag, output int t);
        int n = 0;
        while (sig(sel) !== val && n < budget) begin
            @(negedge clk32);
            n++;
        end
        check({tag, "_wait"}, {31'd0, sig(sel)}, {31'd0, val});
        t = cyc;
    endtask

    task automatic wait_us(input int us);
        repeat (us * DIV) @(negedge clk32);
    endtask

    task automatic send(input logic [7:0] d, input logic atn, input logic eoi);
        tx_data  = d;
        tx_atn   = atn;
        tx_eoi   = eoi;
        tx_valid = 1'b1;
        @(negedge clk32);
        tx_valid = 1'b0;
    endtask

    // Receive one frame from CLK release through bit 7's high phase.
    task automatic recv_byte(input string tag, input logic [7:0] exp_b, output int t_end);
        int t0, t1, t2;
        int lo_min = 1 << 30;
        int lo_max = 0;
        int hi_min = 1 << 30;
        int hi_max = 0;
        logic [7:0] b;
        wait_sig(S_CLK, 1'b1, 400, {tag, "_rel"}, t0);
        wait_sig(S_CLK, 1'b0, 400, {tag, "_b0"}, t0);
        t2 = t0;
        for (int i = 0; i < 8; i++) begin
            wait_sig(S_CLK, 1'b1, BIT_HI + 8, {tag, "_hi"}, t1);
            b[i] = iec_data_o;
            wait_sig(S_CLK, 1'b0, BIT_HI + 8, {tag, "_lo"}, t2);
            if (t1 - t0 < lo_min) lo_min = t1 - t0;
            if (t1 - t0 > lo_max) lo_max = t1 - t0;
            if (t2 - t1 < hi_min) hi_min = t2 - t1;
            if (t2 - t1 > hi_max) hi_max = t2 - t1;
            t0 = t2;
        end
        check({tag, "_byte"}, {24'd0, b}, {24'd0, exp_b});
        check_rng({tag, "_lo_min"}, lo_min, BIT_LO, BIT_HI);
        check_rng({tag, "_lo_max"}, lo_max, BIT_LO, BIT_HI);
        check_rng({tag, "_hi_min"}, hi_min, BIT_LO, BIT_HI);
        check_rng({tag, "_hi_max"}, hi_max, BIT_LO, BIT_HI);
        t_end = t2;
    endtask

    initial begin
        int t_a, t_b, t_e, d0;
        tx_valid = 1'b0;
        tx_atn   = 1'b0;
        tx_eoi   = 1'b0;
        tx_data  = 8'h00;
        lst_data = 1'b1;
        reset_n  = 1'b1;

        // Reset state.
        #5 reset_n = 1'b0;
        repeat (3) @(negedge clk32);
        check("rst_atn", {31'd0, iec_atn_o}, 32'd1);
        check("rst_clk", {31'd0, iec_clk_o}, 32'd1);
        check("rst_data", {31'd0, iec_data_o}, 32'd1);
        check("rst_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, error}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        repeat (8) @(negedge clk32);

        // ATN 0x28 with EOI: listen, frame ack, ATN released, one done.
        d0 = n_done;
        send(8'h28, 1'b1, 1'b1);
        check("atn_ready_low", {31'd0, tx_ready}, 32'd0);
        check("atn_busy", {31'd0, busy}, 32'd1);
        wait_sig(S_ATN, 1'b0, 10, "atn_fall", t_a);
        check("atn_start_clk", {31'd0, iec_clk_o}, 32'd0);
        wait_us(30);
        lst_data = 1'b0;
        wait_sig(S_CLK, 1'b1, 200, "atn_clk_rel", t_b);
        lst_data = 1'b1;
        recv_byte("atn28", 8'h28, t_e);
        check("atn28_atn_during", {31'd0, iec_atn_o}, 32'd0);
        wait_us(20);
        lst_data = 1'b0;
        wait_sig(S_ATN, 1'b1, 200, "atn_rise", t_a);
        wait_sig(S_DONE, 1'b1, 30 * DIV, "atn_done", t_b);
        check_rng("atn_end_hold", t_b - t_a, 20 * DIV, 21 * DIV + 2);
        check("atn_end_clk", {31'd0, iec_clk_o}, 32'd1);
        lst_data = 1'b1;
        repeat (2) @(negedge clk32);
        check("atn_done_cnt", n_done, d0 + 1);

        // Data 0xA5 with EOI: CLK stays released through the EOI handshake.
        d0 = n_done;
        send(8'hA5, 1'b0, 1'b1);
        wait_us(199);
        check("eoi_clk_rel", {31'd0, iec_clk_o}, 32'd1);
        wait_us(1);
        lst_data = 1'b0;
        wait_us(60);
        check("eoi_clk_rel_ack", {31'd0, iec_clk_o}, 32'd1);
        lst_data = 1'b1;
        recv_byte("eoiA5", 8'hA5, t_e);
        wait_us(20);
        lst_data = 1'b0;
        wait_sig(S_DONE, 1'b1, 100, "eoi_done", t_b);
        lst_data = 1'b1;
        repeat (2) @(negedge clk32);
        check("eoi_done_cnt", n_done, d0 + 1);
        check("eoi_idle_clk_low", {31'd0, iec_clk_o}, 32'd0);
        check("eoi_idle_ready", {31'd0, tx_ready}, 32'd1);

        // Data byte with no frame ack: error TMO after bit 7 ends.
        d0 = n_done;
        send(8'h3C, 1'b0, 1'b0);
        recv_byte("noack3C", 8'h3C, t_e);
        wait_sig(S_ERR, 1'b1, TMO_BUDGET, "noack_err", t_b);
        check_rng("noack_tmo", t_b - t_e, TMO * DIV, (TMO + 1) * DIV + 2);
        check("noack_clk", {31'd0, iec_clk_o}, 32'd1);
        check("noack_data", {31'd0, iec_data_o}, 32'd1);
        check("noack_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk32);
        check("noack_no_done", n_done, d0);

        // ATN byte, no device: error 1000 +/- 1 us after ATN falls.
        d0 = n_done;
        send(8'h28, 1'b1, 1'b1);
        wait_sig(S_ATN, 1'b0, 10, "nodev_atn", t_a);
        wait_sig(S_ERR, 1'b1, TMO_BUDGET, "nodev_err", t_b);
        check_rng("nodev_tmo", t_b - t_a, (TMO - 1) * DIV, (TMO + 1) * DIV);
        check("nodev_atn_rel", {31'd0, iec_atn_o}, 32'd1);
        check("nodev_clk_rel", {31'd0, iec_clk_o}, 32'd1);
        check("nodev_data_rel", {31'd0, iec_data_o}, 32'd1);
        repeat (2) @(negedge clk32);
        check("nodev_no_done", n_done, d0);

        // tx_valid held high: one accept per IDLE visit, ATN kept between
        // bytes, second ATN byte skips ATN_START.
        d0 = n_accept;
        tx_data  = 8'h20;
        tx_atn   = 1'b1;
        tx_eoi   = 1'b0;
        tx_valid = 1'b1;
        wait_sig(S_ATN, 1'b0, 10, "hold_atn", t_a);
        check("hold_ready_low", {31'd0, tx_ready}, 32'd0);
        wait_us(10);
        lst_data = 1'b0;
        wait_sig(S_CLK, 1'b1, 200, "hold_clk_rel", t_b);
        lst_data = 1'b1;
        tx_data = 8'h3F;
        tx_eoi  = 1'b1;
        recv_byte("hold20", 8'h20, t_e);
        check("hold_accept1", n_accept, d0 + 1);
        wait_us(10);
        lst_data = 1'b0;
        wait_sig(S_DONE, 1'b1, 100, "hold_done1", t_b);
        check("hold_atn_kept", {31'd0, iec_atn_o}, 32'd0);
        check("hold_accept_at_done", n_accept, d0 + 1);
        lst_data = 1'b1;
        @(negedge clk32);
        tx_valid = 1'b0;
        check("hold_accept2", n_accept, d0 + 2);
        check("hold_ready_low2", {31'd0, tx_ready}, 32'd0);
        recv_byte("hold3F", 8'h3F, t_e);
        wait_us(10);
        lst_data = 1'b0;
        wait_sig(S_ATN, 1'b1, 200, "hold_atn_rel", t_a);
        wait_sig(S_DONE, 1'b1, 30 * DIV, "hold_done2", t_b);
        lst_data = 1'b1;
        repeat (2) @(negedge clk32);
        check("hold_accept_total", n_accept, d0 + 2);

        // ATN listen without EOI, then a data byte: ATN_END first, no done.
        send(8'h48, 1'b1, 1'b0);
        wait_sig(S_ATN, 1'b0, 10, "mix_atn", t_a);
        wait_us(10);
        lst_data = 1'b0;
        wait_sig(S_CLK, 1'b1, 200, "mix_clk_rel", t_b);
        lst_data = 1'b1;
        recv_byte("mix48", 8'h48, t_e);
        wait_us(10);
        lst_data = 1'b0;
        wait_sig(S_DONE, 1'b1, 100, "mix_done1", t_b);
        lst_data = 1'b1;
        repeat (2) @(negedge clk32);
        d0 = n_done;
        check("mix_atn_held", {31'd0, iec_atn_o}, 32'd0);
        send(8'h55, 1'b0, 1'b0);
        wait_sig(S_ATN, 1'b1, 10, "mix_atn_rel", t_a);
        recv_byte("mix55", 8'h55, t_e);
        check("mix_no_done", n_done, d0);
        wait_us(10);
        lst_data = 1'b0;
        wait_sig(S_DONE, 1'b1, 100, "mix_done2", t_b);
        lst_data = 1'b1;
        repeat (2) @(negedge clk32);
        check("mix_done_cnt", n_done, d0 + 1);
        check("mix_idle_clk_low", {31'd0, iec_clk_o}, 32'd0);

        // Reset during BIT_HIGH of bit 3 releases all lines at once.
        send(8'hC3, 1'b0, 1'b0);
        wait_sig(S_CLK, 1'b1, 400, "rst_rel", t_a);
        wait_sig(S_CLK, 1'b0, 400, "rst_b0", t_a);
        for (int i = 0; i < 3; i++) begin
            wait_sig(S_CLK, 1'b1, BIT_HI + 8, "rst_hi", t_a);
            wait_sig(S_CLK, 1'b0, BIT_HI + 8, "rst_lo", t_a);
        end
        wait_sig(S_CLK, 1'b1, BIT_HI + 8, "rst_b3hi", t_a);
        check("rst_b3_data", {31'd0, iec_data_o}, 32'd0);
        wait_us(10);
        @(posedge clk32);
        #3 reset_n = 1'b0;
        #1;
        check("midrst_clk", {31'd0, iec_clk_o}, 32'd1);
        check("midrst_data", {31'd0, iec_data_o}, 32'd1);
        check("midrst_atn", {31'd0, iec_atn_o}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk32);
        reset_n = 1'b1;
        repeat (4) @(negedge clk32);
        check("postrst_ready", {31'd0, tx_ready}, 32'd1);
        d0 = n_done;
        send(8'h96, 1'b0, 1'b0);
        recv_byte("post96", 8'h96, t_e);
        wait_us(10);
        lst_data = 1'b0;
        wait_sig(S_DONE, 1'b1, 100, "post_done", t_b);
        lst_data = 1'b1;
        repeat (2) @(negedge clk32);
        check("post_done_cnt", n_done, d0 + 1);

        // Global tallies.
        check("no_done_and_err", n_both, 0);
        check("err_total", n_err, 2);
        check("accept_total", n_accept, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/iec_talker.md
IEC_TALKER -- requirements
Module: iec_talker

Interface
REQ-001 Parameter CLK_DIV, default 32: clk32 cycles per 1 us tick.
REQ-002 Parameter BIT_US, default 60: duration of each CLK-low and CLK-high bit phase, in us.
REQ-003 Parameter EOI_US, default 200: CLK-released hold time that signals EOI, in us.
REQ-004 Parameter TMO_US, default 1000: listener-response timeout, in us.
REQ-005 Port list (name, direction, width, meaning):
- clk32  in  1  the one clock; 32 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- tx_valid  in  1  byte request.
- tx_data  in  8  byte to send, LSB first.
- tx_atn  in  1  send the byte under ATN (command byte).
- tx_eoi  in  1  last byte. Data byte: signal EOI. ATN byte: release ATN after the frame ack.
- tx_ready  out  1  accept strobe; high only in IDLE.
- done  out  1  one-cycle pulse when a byte is acknowledged.
- error  out  1  one-cycle pulse on any timeout.
- busy  out  1  high whenever state is not IDLE.
- iec_clk_i, iec_data_i  in  1 each  wired-AND bus levels; 1 = released.
- iec_clk_o, iec_data_o, iec_atn_o  out  1 each  drive; 1 = released, 0 = pulled low.

Function
REQ-006 iec_clk_i and iec_data_i SHALL pass through 2-flop synchronizers; all decisions SHALL use the synchronized values.
REQ-007 A free-running prescaler SHALL produce a 1-cycle us_tick every CLK_DIV cycles. All timers SHALL count us_tick, with tolerance +0/+1 us.
REQ-008 A transfer SHALL be accepted on tx_valid & tx_ready. tx_data, tx_atn and tx_eoi SHALL be latched in that cycle. tx_ready SHALL drop the next cycle.
REQ-009 States: IDLE, ATN_START, READY, EOI_WAIT, EOI_ACK, BIT_LOW, BIT_HIGH, FRAME_ACK, ATN_END.
REQ-010 IDLE to ATN_START if tx_atn and ATN is not already asserted; otherwise IDLE to READY.
REQ-011 ATN_START: drive atn_o=0 and clk_o=0, data_o=1. Go to READY once data_i=0. If data_i stays 1 for TMO_US, go to error ("no device").
REQ-012 READY: release clk_o (1). Wait with no timeout for data_i=1 (listener ready).
- Then, if a data byte with tx_eoi: go to EOI_WAIT.
- Otherwise: pull clk_o=0 and go to BIT_LOW.
REQ-013 EOI_WAIT: keep clk_o=1. Wait for data_i=0 (listener EOI ack) then go to EOI_ACK. If data_i stays 1 for TMO_US, go to error.
- EOI_ACK: wait for data_i=1, then pull clk_o=0 and go to BIT_LOW.
REQ-014 BIT_LOW: clk_o=0, data_o = current bit (1 = released), held BIT_US.
- BIT_HIGH: clk_o=1 with the same data_o, held BIT_US.
- Bit index SHALL count 0..7 (3-bit, no wrap beyond 7). After bit 7's BIT_HIGH, drive clk_o=0, data_o=1, go to FRAME_ACK.
REQ-015 FRAME_ACK: wait up to TMO_US for data_i=0, else go to error ("frame error").
- On ack: if an ATN byte with tx_eoi, go to ATN_END. Otherwise pulse done and go to IDLE with clk_o held 0.
REQ-016 ATN_END: release atn_o, hold 20 us, release clk_o, pulse done, go to IDLE.
REQ-017 Consecutive ATN bytes without tx_eoi SHALL keep atn_o=0 across IDLE and skip ATN_START.
REQ-018 A data byte accepted while ATN is still asserted SHALL first run ATN_END (without a done pulse), then proceed to READY.
REQ-019 Error: pulse error and release atn_o, clk_o, data_o in the same cycle, clear the ATN-held flag, go to IDLE.
REQ-020 tx_valid in a non-IDLE state SHALL be ignored. done and error SHALL never pulse in the same cycle.
REQ-021 Simultaneous listener edge and timer expiry: the edge SHALL win.

Reset
REQ-022 reset_n=0 SHALL asynchronously force:
- state IDLE;
- iec_atn_o, iec_clk_o, iec_data_o = 1;
- tx_ready=1, done=0, error=0, busy=0;
- prescaler, timers, bit index and synchronizers cleared; ATN-held flag cleared.
REQ-023 Reset asserted mid-transfer SHALL release all bus lines immediately, without waiting for a clock edge.

Verification
REQ-024 ATN 0x28 with tx_eoi=1, listener model pulls DATA within 50 us:
- atn_o low; 8 bits 0,0,0,1,0,1,0,0 each 60 us low / 60 us high;
- frame ack, atn_o released, done once.
REQ-025 ATN byte, bus DATA never pulled: error pulse 1000±1 us after atn_o falls, all lines released, no done.
REQ-026 Data 0xA5 with tx_eoi=1:
- clk_o stays released until the listener pulls DATA at 200 us, holds it 60 us and releases;
- bits 1,0,1,0,0,1,0,1 follow; done; clk_o remains low in IDLE.
REQ-027 Data byte where the listener never acks the frame: error exactly TMO_US after bit 7 ends.
REQ-028 reset_n pulled low during BIT_HIGH of bit 3: all outputs released in the same cycle; after release, tx_ready=1 and the next byte completes normally.
REQ-029 tx_valid held high through a whole transfer: exactly one byte accepted per IDLE visit; tx_ready low for the whole transfer.
